uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
8N1 UART receiver. It is the downstream counterpart of the team's UART transmitter and consumes the serial line that the transmitter drives. Each received frame is deserialized by sampling at mid-bit, using a clock-cycle baud counter. The byte is presented to the core-side peripheral bus through a valid/ack handshake, with framing-error and overrun status.

Parameters:
CLKS_PER_BIT, 868, CLK cycles per bit period (100 MHz / 115200); legal range >= 4.

Ports:
CLK  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Rx  input  1  serial line, idle high, asynchronous to CLK
rx_ack  input  1  consumer has read rx_data; one-cycle pulse
rx_data  output  8  last accepted byte
rx_valid  output  1  rx_data holds an unread byte
frame_err  output  1  stop bit of the byte in rx_data sampled low
overrun  output  1  at least one byte was discarded while rx_valid=1
rx_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - rx_data=0x00; rx_valid, frame_err, overrun, rx_busy all 0.
  - Both synchronizer flops are set to 1.
  - FSM goes to IDLE; baud and bit counters are cleared.
  - Reset mid-frame abandons the frame, and no partial byte is ever exposed.
- Synchronizer: Rx passes through 2 flops to give rx_s. All sampling uses rx_s, so there is 2-cycle input latency.
- Baud counter: counts 0..CLKS_PER_BIT-1, cleared on every state transition. Bit index counts 0..7.
- FSM states:
  - IDLE:
    - rx_busy=0.
    - The cycle in which rx_s=0 is t0; at t0 the FSM goes to START.
  - START:
    - At baud count CLKS_PER_BIT/2-1 (integer division), sample rx_s.
    - If rx_s=0, go to DATA.
    - If rx_s=1, treat it as a glitch and return to IDLE; no status changes.
  - DATA:
    - At baud count CLKS_PER_BIT-1, sample rx_s into the shift register, LSB first.
    - After the 8th sample, go to STOP.
    - Data bit k is sampled at t0 + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT.
  - STOP: at baud count CLKS_PER_BIT-1, sample the stop bit.
    - If rx_s=1, the frame completes with fe=0 and the FSM goes to IDLE.
    - If rx_s=0, the frame completes with fe=1 and the FSM goes to BREAK_WAIT.
  - BREAK_WAIT: rx_busy=1. Stay until rx_s=1, then go to IDLE. A held-low line never starts a new frame.
- Frame completion (registered; outputs update the cycle after the stop sample):
  - If rx_valid=0, or rx_ack=1 in the completion cycle: rx_data<=byte, rx_valid<=1, frame_err<=fe, overrun<=0.
  - If rx_valid=1 and rx_ack=0: the new byte is discarded. rx_data and frame_err are held, and overrun<=1.
- rx_ack:
  - With rx_valid=1 and no completion that cycle: next cycle rx_valid, frame_err and overrun go to 0. rx_data is held.
  - rx_ack with rx_valid=0 is ignored.
- rx_ack has no effect on reception; the FSM never stalls.

Test Plan:
All scenarios use CLKS_PER_BIT=16.
1. Clean frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB-first, stop=1) -> rx_valid rises at t0+153, rx_data=0xA5, frame_err=0, overrun=0. rx_busy is 1 from t0+1 until the IDLE return at t0+153.
2. Rx low for 4 cycles then high -> no rx_valid, and rx_busy drops by t0+9. A clean 0x3C sent afterwards is received correctly.
3. Frame 0x3C with stop=0, then line held low 40 cycles, then high -> rx_data=0x3C, frame_err=1, rx_busy stays 1 until rx_s returns high, and no second frame is reported.
4. Back-to-back 0x11 and 0x22 with no rx_ack -> rx_data=0x11, rx_valid=1, overrun=1. Pulse rx_ack -> next cycle rx_valid=0, overrun=0, rx_data=0x11.
5. Unread 0x11; pulse rx_ack exactly in the completion cycle of 0x55 -> rx_valid stays 1, rx_data=0x55, overrun=0.
6. Assert reset at t0+80 during data bits, release after 3 cycles -> all outputs at reset values immediately. The next frame 0x0F gives rx_data=0x0F, rx_valid=1, frame_err=0.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Rx is double-synchronized and sampled at mid-bit by
// a clock-cycle baud counter. Received bytes are handed to the core side
// through a valid/ack handshake, with framing-error and overrun status.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       Rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BRK   = 3'd4;

  logic          r_sync1, r_sync2;
  logic [2:0]    r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid, r_fe, r_ovr;

  logic          w_rx_s;
  logic [2:0]    w_next;
  logic          w_sample;   // data-bit sample strobe
  logic          w_done;     // frame completes this cycle
  logic          w_fe;       // stop bit sampled low

  assign w_rx_s = r_sync2;

  // Two-flop synchronizer; resets to idle-high so reset never looks like a start bit
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= Rx;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state decode and sample/complete strobes
  always_comb begin
    w_next   = r_state;
    w_sample = 1'b0;
    w_done   = 1'b0;
    w_fe     = 1'b0;
    case (r_state)
      S_IDLE:  if (!w_rx_s) w_next = S_START;
      S_START: if (r_baud == HALF_M1) w_next = w_rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (r_baud == FULL_M1) begin
          w_sample = 1'b1;
          if (r_bit == 3'd7) w_next = S_STOP;
        end
      end
      S_STOP: begin
        if (r_baud == FULL_M1) begin
          w_done = 1'b1;
          w_fe   = ~w_rx_s;
          w_next = w_rx_s ? S_IDLE : S_BRK;
        end
      end
      S_BRK:   if (w_rx_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM state, baud counter (cleared on every transition and at bit end), bit index, shifter
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || r_baud == FULL_M1 || r_state == S_IDLE || r_state == S_BRK)
        r_baud <= '0;
      else
        r_baud <= r_baud + CW'(1);
      if (r_state != S_DATA)
        r_bit <= '0;
      else if (w_sample)
        r_bit <= r_bit + 3'd1;
      if (w_sample)
        r_shift <= {w_rx_s, r_shift[7:1]};
    end
  end

  // Output handshake: completion wins over ack; an unread byte blocks the new one
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_done) begin
      if (!r_valid || rx_ack) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        r_fe    <= w_fe;
        r_ovr   <= 1'b0;
      end else begin
        r_ovr   <= 1'b1;
      end
    end else if (rx_ack && r_valid) begin
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_fe;
  assign overrun   = r_ovr;
  assign rx_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit. Accepted frames are
// pushed to a scoreboard when sent and popped when rx_data is presented.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       Rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, rx_busy;

  typedef struct packed { logic [7:0] d; logic fe; } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_pass = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .reset(reset), .Rx(Rx), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .overrun(overrun), .rx_busy(rx_busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge CLK) Rx = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      repeat (CPB) @(negedge CLK);
    end
    Rx = stop;
    repeat (CPB) @(negedge CLK);
  endtask

  task automatic wait_busy();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (rx_busy) begin ok = 1'b1; break; end
    end
    check("busy_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (rx_valid) begin ok = 1'b1; break; end
    end
    check("valid_seen", 32'(ok), 32'd1);
  endtask

  task automatic ack_pulse();
    @(negedge CLK) rx_ack = 1'b1;
    @(negedge CLK) rx_ack = 1'b0;
    check("ack_valid_clr", 32'(rx_valid), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"},  32'(rx_data),   32'd0);
    check({tag, "_valid"}, 32'(rx_valid),  32'd0);
    check({tag, "_fe"},    32'(frame_err), 32'd0);
    check({tag, "_ovr"},   32'(overrun),   32'd0);
    check({tag, "_busy"},  32'(rx_busy),   32'd0);
  endtask

  // Monitor: a newly presented byte is valid rising, or new data while valid
  initial begin : mon
    logic       pv;
    logic [7:0] pd;
    exp_t       e;
    pv = 1'b0;
    pd = 8'h00;
    forever begin
      @(negedge CLK);
      if (!reset) begin
        pv = 1'b0;
        pd = 8'h00;
      end else begin
        if (rx_valid && (!pv || rx_data != pd)) begin
          check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("frame_data", 32'(rx_data),   32'(e.d));
            check("frame_fe",   32'(frame_err), 32'(e.fe));
            check("frame_ovr",  32'(overrun),   32'd0);
          end
        end
        pv = rx_valid;
        pd = rx_data;
      end
    end
  end

  initial begin : main
    int lat, nb;
    repeat (3) @(negedge CLK);
    check_reset_vals("rst0");
    reset = 1'b1;
    repeat (10) @(negedge CLK);

    // 1: clean 0xA5, latency busy-rise -> valid-rise is 152 cycles
    sb.push_back('{d: 8'hA5, fe: 1'b0});
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_busy();
        lat = 0; nb = 1;
        for (int k = 1; k <= 400; k++) begin
          @(negedge CLK);
          if (rx_valid) begin lat = k; break; end
          if (rx_busy) nb++;
        end
        check("s1_latency", 32'(lat), 32'd152);
        check("s1_busy_len", 32'(nb), 32'd152);
        check("s1_busy_end", 32'(rx_busy), 32'd0);
      end
    join
    ack_pulse();

    // 2: 4-cycle glitch is rejected, then clean 0x3C
    @(negedge CLK) Rx = 1'b0;
    repeat (4) @(negedge CLK);
    check("s2_busy_hi", 32'(rx_busy), 32'd1);
    Rx = 1'b1;
    repeat (12) @(negedge CLK);
    check("s2_busy_lo", 32'(rx_busy), 32'd0);
    check("s2_no_valid", 32'(rx_valid), 32'd0);
    sb.push_back('{d: 8'h3C, fe: 1'b0});
    send_frame(8'h3C, 1'b1);
    wait_valid();
    ack_pulse();

    // 3: framing error then break held low
    sb.push_back('{d: 8'h3C, fe: 1'b1});
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge CLK);
    check("s3_busy_brk", 32'(rx_busy), 32'd1);
    check("s3_data", 32'(rx_data), 32'h3C);
    check("s3_fe", 32'(frame_err), 32'd1);
    Rx = 1'b1;
    repeat (5) @(negedge CLK);
    check("s3_busy_rel", 32'(rx_busy), 32'd0);
    repeat (40) @(negedge CLK);
    ack_pulse();

    // 4: back-to-back without ack -> overrun, ack clears it
    sb.push_back('{d: 8'h11, fe: 1'b0});
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (4) @(negedge CLK);
    check("s4_data", 32'(rx_data), 32'h11);
    check("s4_valid", 32'(rx_valid), 32'd1);
    check("s4_ovr", 32'(overrun), 32'd1);
    @(negedge CLK) rx_ack = 1'b1;
    @(negedge CLK) rx_ack = 1'b0;
    check("s4_ack_valid", 32'(rx_valid), 32'd0);
    check("s4_ack_ovr", 32'(overrun), 32'd0);
    check("s4_ack_data", 32'(rx_data), 32'h11);

    // 5: ack coincides with completion of the next byte
    sb.push_back('{d: 8'h11, fe: 1'b0});
    send_frame(8'h11, 1'b1);
    wait_valid();
    sb.push_back('{d: 8'h55, fe: 1'b0});
    fork
      send_frame(8'h55, 1'b1);
      begin
        wait_busy();
        repeat (151) @(negedge CLK);
        rx_ack = 1'b1;
        @(negedge CLK) rx_ack = 1'b0;
        check("s5_valid", 32'(rx_valid), 32'd1);
        check("s5_data", 32'(rx_data), 32'h55);
        check("s5_ovr", 32'(overrun), 32'd0);
      end
    join
    repeat (5) @(negedge CLK);

    // 6: reset mid-frame, then a clean 0x0F
    fork
      send_frame(8'hF3, 1'b1);
      begin
        wait_busy();
        repeat (79) @(negedge CLK);
        reset = 1'b0;
        #1;
        check_reset_vals("s6_rst");
        repeat (3) @(negedge CLK);
        reset = 1'b1;
      end
    join
    repeat (20) @(negedge CLK);
    check("s6_no_valid", 32'(rx_valid), 32'd0);
    sb.push_back('{d: 8'h0F, fe: 1'b0});
    send_frame(8'h0F, 1'b1);
    wait_valid();
    check("s6_data", 32'(rx_data), 32'h0F);
    check("s6_fe", 32'(frame_err), 32'd0);

    repeat (20) @(negedge CLK);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
